// File: rtl/sar_pkg.sv
// Shared definitions for the SAR sequencer: FSM state codes and the
// accumulator / FIFO-level widths of the default configuration.
package sar_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t CONV = 2'b01;
    localparam state_t GAP  = 2'b10;
    localparam state_t PUSH = 2'b11;

    localparam int DEF_N        = 8;
    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_DEPTH    = 4;

    localparam int ACC_W = DEF_N + DEF_AVG_LOG2;
    localparam int LVL_W = $clog2(DEF_DEPTH + 1);

    // Width helpers so parameterised instances size themselves consistently.
    function automatic int acc_width(input int n, input int avg_log2);
        return n + avg_log2;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sar_sequencer_if.sv
// Signal bundle between the sequencer, the SAR controller (go/valid/result)
// and the downstream consumer (valid/ready output stream).
interface sar_sequencer_if #(
    parameter int N = 8
);
    logic         sar_go;
    logic         sar_valid;
    logic [N-1:0] sar_result;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output sar_go, out_data, out_valid,
        input  sar_valid, sar_result, out_ready
    );

    modport slave (
        input  sar_go, out_data, out_valid,
        output sar_valid, sar_result, out_ready
    );
endinterface

// File: rtl/sar_seq_fifo.sv
// Circular-buffer output FIFO for averaged codes; head data reads as zero
// while empty so the output bus is quiet after reset.
module sar_seq_fifo
    import sar_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [N-1:0]                  push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic [N-1:0]                  head
);
    localparam int LW    = level_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign level = level_q;
    assign head  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/sar_sequencer.sv
// SAR sequencer top: paces the controller's go line, averages 2^AVG_LOG2 codes
// and queues the results. Optional CONV watchdog enabled by SAR_SEQ_TIMEOUT_EN.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int N        = 8,
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    sar_sequencer_if.master               bus,
    output logic [level_width(DEPTH)-1:0] fifo_level,
    output logic                          busy,
    output logic                          err
);
    localparam int SUM_W = acc_width(N, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [N-1:0]     avg_code;
    logic             timeout_hit;

    // Truncating divide by 2^AVG_LOG2; the sum never overflows SUM_W.
    function automatic logic [N-1:0] avg_trunc(input logic [SUM_W-1:0] sum);
        return sum[SUM_W-1:AVG_LOG2];
    endfunction

`ifdef SAR_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;

    assign timeout_hit = en && (state_q == CONV) && !bus.sar_valid &&
                         (wdog_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        wdog_d = (state_q == CONV) ? wdog_q + 1'b1 : '0;
        err_d  = err_q | timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    assign fifo_pop = !fifo_empty && bus.out_ready;
    assign avg_code = avg_trunc(acc_q);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = CONV;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (bus.sar_valid) begin
                    acc_d   = acc_q + SUM_W'(bus.sar_result);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_LAST) ? PUSH : GAP;
                end else if (timeout_hit) begin
                    state_d = GAP;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = CONV;
                end
            end
            PUSH: begin
                // Stall here with go low until the FIFO can take the average.
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = en ? CONV : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    sar_seq_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (avg_code),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (bus.out_data)
    );

    assign bus.sar_go    = (state_q == CONV);
    assign bus.out_valid = !fifo_empty;
    assign busy          = (state_q != IDLE);

endmodule
